fma_arbiter: RTL and testbench
==============================

FMA_ARBITER -- requirements
Module: fma_arbiter

Interface
REQ-001 Parameter W, 32, width of each operand and of the result.
REQ-002 Parameter TIMEOUT, 64, maximum cycles spent in WAIT before an error response.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 Port req0_valid / req1_valid  in  1  requester i presents an operation.
REQ-006 Port req0_ready / req1_ready  out  1  operation of requester i accepted this cycle when valid&ready.
REQ-007 Port req0_op / req1_op  in  1  1 = a*b + c*d, 0 = a*b - c*d.
REQ-008 Port req0_opnds / req1_opnds  in  4*W  {a,b,c,d}, a in MSBs.
REQ-009 Port fma_start  out  1  one-cycle launch pulse to the shared fused multiply-add unit.
REQ-010 Port fma_op  out  1  latched op, stable from fma_start until response accepted.
REQ-011 Port fma_opnds  out  4*W  latched operands, same stability as fma_op.
REQ-012 Port fma_done  in  1  unit result valid, single-cycle pulse.
REQ-013 Port fma_result  in  W  unit result, valid with fma_done.
REQ-014 Port rsp_valid  out  1  response available.
REQ-015 Port rsp_ready  in  1  consumer accepts response when valid&ready.
REQ-016 Port rsp_id  out  1  requester index (0/1) owning the response.
REQ-017 Port rsp_data  out  W  captured fma_result.
REQ-018 Port rsp_err  out  1  response terminated by timeout.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
REQ-020 IDLE: reqi_ready = granted(i), combinational; grant = sole valid requester, or, if both valid, requester selected by round-robin pointer; no ready outside IDLE.
REQ-021 Handshake in IDLE: op, opnds and id latched; pointer set to the other requester; next state ISSUE.
REQ-022 ISSUE: fma_start=1 for exactly one cycle; next state WAIT; fma_done ignored in IDLE and ISSUE.
REQ-023 WAIT: on fma_done, capture fma_result into rsp_data, rsp_err=0, go to RESP.
REQ-024 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err held stable until rsp_valid&rsp_ready; then IDLE next cycle.
REQ-025 Latency: handshake cycle 0, fma_start cycle 1, fma_done cycle k, rsp_valid cycle k+1; next acceptance no earlier than the cycle after response handshake.
REQ-026 fma_op/fma_opnds drive latched values from ISSUE through RESP; zero in IDLE.
REQ-027 Pointer toggles only on grant; single-requester traffic does not starve the other.

Reset
REQ-028 rst_n=0 at a rising edge: state IDLE, pointer=0 (req0 priority), latched op/opnds/id/data/err=0, timeout counter=0.
REQ-029 During and on the cycle after reset: fma_start, rsp_valid, req0_ready, req1_ready = 0.
REQ-030 Reset in ISSUE/WAIT/RESP aborts the operation without a response; a subsequent fma_done in IDLE is ignored.

Configuration
REQ-031 Macro FMA_ARB_TIMEOUT_EN defined: counter clears on entry to WAIT, increments each WAIT cycle; after TIMEOUT cycles with no fma_done, go to RESP with rsp_err=1, rsp_data=0; fma_done in the expiry cycle wins (err=0).
REQ-032 Macro undefined: no counter, WAIT held indefinitely until fma_done, rsp_err tied 0, TIMEOUT unused.

Verification
REQ-033 rst_n=0 3 cycles with req0_valid=req1_valid=1 -> all outputs 0, no handshake, pointer=0 afterwards.
REQ-034 req0 op=1 opnds {0x3F800000,0x40000000,0x40400000,0x3F800000}, model done 3 cycles after start with 0x40A00000 -> ready cycle 0, fma_start cycle 1 only, rsp_valid cycle 5, id=0, data=0x40A00000, err=0.
REQ-035 Both requesters valid continuously, 4 ops, rsp_ready=1 -> grant order 0,1,0,1; exactly one fma_start per op.
REQ-036 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/id/data stable, both readys 0, fma_op/opnds stable, no fma_start.
REQ-037 With FMA_ARB_TIMEOUT_EN, TIMEOUT=16, no fma_done -> rsp_valid, err=1, data=0 after 16 WAIT cycles; without macro, still in WAIT after 100 cycles.
REQ-038 rst_n=0 one cycle during WAIT, fma_done 2 cycles later -> IDLE, no rsp_valid, next request served normally with req0 priority.

Source files
------------

// File: rtl/fma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fma_arbiter
// Description : Round-robin arbiter sharing one fused multiply-add unit
//               between two requesters. Optional WAIT watchdog enabled by
//               defining FMA_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fma_arbiter #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic           req0_op,
    input  logic [4*W-1:0] req0_opnds,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic           req1_op,
    input  logic [4*W-1:0] req1_opnds,
    output logic           fma_start,
    output logic           fma_op,
    output logic [4*W-1:0] fma_opnds,
    input  logic           fma_done,
    input  logic [W-1:0]   fma_result,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_ptr;
    logic           r_live;
    logic           r_op;
    logic           r_id;
    logic [4*W-1:0] r_opnds;
    logic [W-1:0]   r_data;

    logic w_idle;
    logic w_gnt0;
    logic w_gnt1;
    logic w_hs;

    // r_live keeps both readys low for the first cycle after reset release
    assign w_idle     = (r_state == S_IDLE) && r_live && rst_n;
    assign w_gnt0     = req0_valid && (!req1_valid || !r_ptr);
    assign w_gnt1     = req1_valid && (!req0_valid ||  r_ptr);
    assign req0_ready = w_idle && w_gnt0;
    assign req1_ready = w_idle && w_gnt1;
    assign w_hs       = req0_ready || req1_ready;

`ifdef FMA_ARB_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;
    logic               w_expire;

    assign w_expire = (r_cnt == c_cnt_last);
    assign rsp_err  = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = |TIMEOUT;
    assign rsp_err          = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_live  <= 1'b0;
            r_op    <= 1'b0;
            r_id    <= 1'b0;
            r_opnds <= '0;
            r_data  <= '0;
`ifdef FMA_ARB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_op    <= req1_ready ? req1_op    : req0_op;
                        r_opnds <= req1_ready ? req1_opnds : req0_opnds;
                        r_id    <= req1_ready;
                        r_ptr   <= !req1_ready;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef FMA_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // a completion in the expiry cycle takes precedence
                    if (fma_done) begin
                        r_data  <= fma_result;
`ifdef FMA_ARB_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= S_RESP;
                    end
`ifdef FMA_ARB_TIMEOUT_EN
                    else if (w_expire) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fma_start = (r_state == S_ISSUE);
    assign rsp_valid = (r_state == S_RESP);
    assign fma_op    = (r_state != S_IDLE) && r_op;
    assign fma_opnds = (r_state == S_IDLE) ? '0 : r_opnds;
    assign rsp_id    = r_id;
    assign rsp_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_fma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fma_arbiter
// Description : Self-checking bench for fma_arbiter with a behavioural FMA
//               responder and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_arbiter;

    localparam int W   = 32;
    localparam int TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req0_valid, req0_ready, req0_op;
    logic           req1_valid, req1_ready, req1_op;
    logic [4*W-1:0] req0_opnds, req1_opnds;
    logic           fma_start, fma_op, fma_done;
    logic [4*W-1:0] fma_opnds;
    logic [W-1:0]   fma_result;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [W-1:0]   rsp_data;

    always #5 clk = ~clk;

    fma_arbiter #(.W(W), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_opnds (req0_opnds),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_opnds (req1_opnds),
        .fma_start  (fma_start),
        .fma_op     (fma_op),
        .fma_opnds  (fma_opnds),
        .fma_done   (fma_done),
        .fma_result (fma_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    int           checks = 0;
    int           errors = 0;
    int           m_dly  = 2;      // 0 = unit never answers
    logic         m_ovr  = 1'b0;
    logic [W-1:0] m_ovv  = '0;

    typedef struct {
        logic           v0, v1, op0, op1;
        logic [4*W-1:0] o0, o1;
        logic           r0, r1, id;
    } vec_t;

    typedef struct {
        logic           id, op;
        logic [4*W-1:0] opnds;
        int             hs, rsp;
    } txn_t;

    function automatic logic [W-1:0] f_calc(input logic op, input logic [4*W-1:0] o);
        logic [W-1:0] a, b, c, d;
        {a, b, c, d} = o;
        return op ? (a * b + c * d) : (a * b - c * d);
    endfunction

    // shared FMA unit: answers m_dly cycles after the start pulse
    initial begin
        int           cnt;
        logic [W-1:0] res;
        cnt        = 0;
        res        = '0;
        fma_done   = 1'b0;
        fma_result = '0;
        forever begin
            @(negedge clk);
            if (fma_start) begin
                cnt      = m_dly;
                res      = m_ovr ? m_ovv : f_calc(fma_op, fma_opnds);
                fma_done = 1'b0;
            end else if (cnt > 0) begin
                cnt        = cnt - 1;
                fma_done   = (cnt == 0);
                fma_result = fma_done ? res : '0;
            end else begin
                fma_done = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [4*W-1:0] act, input logic [4*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_rsp(input string nm, input logic eid, input logic [W-1:0] edata, input logic eerr);
        int n;
        n = 0;
        do begin
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            #1;
            n++;
        end while (!rsp_valid && n < 100);
        chk({nm, "_rsp_valid"}, rsp_valid, 1'b1);
        chk({nm, "_rsp_id"},    rsp_id,    eid);
        chk({nm, "_rsp_data"},  rsp_data,  edata);
        chk({nm, "_rsp_err"},   rsp_err,   eerr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[6];
        txn_t q[$];
        txn_t t;
        logic ptr, e_r0, e_r1, e_rv;
        int   cyc;

        tv[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 128'h00000003_00000005_00000007_00000002,
                  128'h00000010_00000004_00000001_00000009, 1'b1, 1'b0, 1'b0};
        tv[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 128'h00000011_00000003_00000002_00000002,
                  128'h00000100_00000002_00000005_00000005, 1'b0, 1'b1, 1'b1};
        tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 128'h0,
                  128'h0000000A_0000000B_0000000C_0000000D, 1'b0, 1'b1, 1'b1};
        tv[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 128'h00000001_00000001_00000002_00000003,
                  128'h00000009_00000009_00000009_00000009, 1'b1, 1'b0, 1'b0};
        tv[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 128'hFFFFFFFF_00000002_00000001_00000001,
                  128'h0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 128'h00000002_00000002_00000002_00000002,
                  128'h00000007_00000006_00000005_00000004, 1'b0, 1'b1, 1'b1};

        rst_n      = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op    = 1'b0; req1_op    = 1'b0;
        req0_opnds = '0;   req1_opnds = '0;
        rsp_ready  = 1'b1;
        tick();

        // reset held 3 cycles with both requesters valid
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 1'b1; req0_opnds = 128'h00000002_00000003_00000004_00000005;
        #1;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_ready1", req1_ready, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            #1;
            chk("rst_ready0", req0_ready, 1'b0);
            chk("rst_ready1", req1_ready, 1'b0);
            chk("rst_start",  fma_start,  1'b0);
            chk("rst_rspv",   rsp_valid,  1'b0);
            chk("rst_fop",    fma_op,     1'b0);
            chk("rst_fopnds", fma_opnds,  '0);
            chk("rst_rsp",    {rsp_id, rsp_err, rsp_data}, '0);
        end
        tick(); rst_n = 1'b1; #1;
        chk("post_rst_ready0", req0_ready, 1'b0);
        chk("post_rst_ready1", req1_ready, 1'b0);
        chk("post_rst_start",  fma_start,  1'b0);
        chk("post_rst_rspv",   rsp_valid,  1'b0);
        tick(); #1;
        chk("prio_ready0", req0_ready, 1'b1);
        chk("prio_ready1", req1_ready, 1'b0);
        wait_rsp("prio", 1'b0, f_calc(1'b1, 128'h00000002_00000003_00000004_00000005), 1'b0);

        // table: arbitration sequence from a fresh pointer
        do_reset(2);
        foreach (tv[i]) begin
            req0_valid = tv[i].v0; req1_valid = tv[i].v1;
            req0_op    = tv[i].op0; req1_op   = tv[i].op1;
            req0_opnds = tv[i].o0;  req1_opnds = tv[i].o1;
            #1;
            chk("tv_ready0", req0_ready, tv[i].r0);
            chk("tv_ready1", req1_ready, tv[i].r1);
            wait_rsp("tv", tv[i].id,
                     tv[i].id ? f_calc(tv[i].op1, tv[i].o1) : f_calc(tv[i].op0, tv[i].o0), 1'b0);
            tick();
        end

        // exact latency of a single transaction
        m_dly = 3; m_ovr = 1'b1; m_ovv = 32'h40A00000;
        req0_valid = 1'b1; req1_valid = 1'b0; req0_op = 1'b1;
        req0_opnds = 128'h3F800000_40000000_40400000_3F800000;
        #1;
        chk("lat_ready0", req0_ready, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            tick(); req0_valid = 1'b0; #1;
            chk("lat_start", fma_start, c == 1);
            chk("lat_rspv",  rsp_valid, c == 5);
            if (c == 1) chk("lat_fopnds", fma_opnds, 128'h3F800000_40000000_40400000_3F800000);
            if (c == 1) chk("lat_fop",    fma_op,    1'b1);
            if (c == 5) chk("lat_rsp",    {rsp_id, rsp_err, rsp_data}, {2'b00, 32'h40A00000});
            if (c == 6) chk("lat_idle_opnds", fma_opnds, '0);
        end
        m_ovr = 1'b0;

        // response back-pressure for 10 cycles
        rsp_ready = 1'b0; m_dly = 2;
        req0_valid = 1'b1; req0_op = 1'b0;
        req0_opnds = 128'h00000009_00000008_00000007_00000006;
        #1;
        wait_rsp("stall", 1'b0, f_calc(1'b0, 128'h00000009_00000008_00000007_00000006), 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick(); req0_valid = 1'b1; req1_valid = 1'b1; #1;
            chk("stall_rspv",   rsp_valid, 1'b1);
            chk("stall_data",   rsp_data,  f_calc(1'b0, 128'h00000009_00000008_00000007_00000006));
            chk("stall_id",     rsp_id,    1'b0);
            chk("stall_ready",  {req0_ready, req1_ready}, 2'b00);
            chk("stall_start",  fma_start, 1'b0);
            chk("stall_fopnds", fma_opnds, 128'h00000009_00000008_00000007_00000006);
            chk("stall_fop",    fma_op,    1'b0);
        end
        tick(); req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1; #1;
        chk("stall_last_rspv", rsp_valid, 1'b1);
        tick(); #1;
        chk("stall_done_rspv", rsp_valid, 1'b0);

        // unit never answers
        m_dly = 0; req0_valid = 1'b1;
        req0_opnds = 128'h00000001_00000002_00000003_00000004;
        #1;
`ifdef FMA_ARB_TIMEOUT_EN
        for (int c = 1; c <= TMO + 2; c++) begin
            tick(); req0_valid = 1'b0; #1;
            chk("tmo_rspv", rsp_valid, c == TMO + 2);
        end
        chk("tmo_rsp", {rsp_id, rsp_err, rsp_data}, {2'b01, 32'h0});
        tick();
        // completion arriving in the expiry cycle
        m_dly = TMO; req1_valid = 1'b1; req1_op = 1'b1;
        req1_opnds = 128'h00000005_00000006_00000007_00000008;
        #1;
        for (int c = 1; c <= TMO + 2; c++) begin
            tick(); req1_valid = 1'b0; #1;
            chk("tmo_win_rspv", rsp_valid, c == TMO + 2);
        end
        chk("tmo_win_rsp", {rsp_id, rsp_err, rsp_data},
            {2'b10, f_calc(1'b1, 128'h00000005_00000006_00000007_00000008)});
        tick();
`else
        for (int c = 1; c <= 100; c++) begin
            tick(); req0_valid = 1'b0; #1;
            chk("hang_rspv", rsp_valid, 1'b0);
        end
        do_reset(1);
`endif

        // reset during WAIT, late completion must be ignored
        m_dly = 4; req0_valid = 1'b1; req1_valid = 1'b0; req0_op = 1'b1;
        req0_opnds = 128'h00000003_00000003_00000003_00000003;
        #1;
        chk("abort_ready0", req0_ready, 1'b1);
        tick(); req0_valid = 1'b0;
        tick();
        tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1; #1;
        chk("abort_fopnds", fma_opnds, '0);
        for (int c = 4; c <= 8; c++) begin
            if (c > 4) tick();
            #1;
            chk("abort_rspv",  rsp_valid, 1'b0);
            chk("abort_start", fma_start, 1'b0);
        end
        tick(); req0_valid = 1'b1; req1_valid = 1'b1; #1;
        chk("abort_next_ready", {req0_ready, req1_ready}, 2'b10);
        wait_rsp("abort_next", 1'b0, f_calc(1'b1, 128'h00000003_00000003_00000003_00000003), 1'b0);
        tick();

        // randomized traffic against the transaction-level model
        do_reset(2);
        ptr = 1'b0;
        cyc = 0;
        for (int n = 0; n < 500; n++) begin
            if (n > 0) tick();
            if (q.size() == 0) m_dly = $urandom_range(1, 5);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            req0_op    = $urandom_range(0, 1) == 1;
            req1_op    = $urandom_range(0, 1) == 1;
            req0_opnds = {$urandom, $urandom, $urandom, $urandom};
            req1_opnds = {$urandom, $urandom, $urandom, $urandom};
            rsp_ready  = $urandom_range(0, 3) != 0;
            #1;
            e_r0 = (q.size() == 0) && req0_valid && (!req1_valid || !ptr);
            e_r1 = (q.size() == 0) && req1_valid && (!req0_valid ||  ptr);
            chk("rnd_ready0", req0_ready, e_r0);
            chk("rnd_ready1", req1_ready, e_r1);
            chk("rnd_start",  fma_start,  (q.size() != 0) && (cyc == q[0].hs + 1));
            if (q.size() == 0) begin
                chk("rnd_idle_opnds", {fma_op, fma_opnds}, '0);
            end else if (cyc > q[0].hs) begin
                chk("rnd_fopnds", fma_opnds, q[0].opnds);
                chk("rnd_fop",    fma_op,    q[0].op);
            end
            e_rv = (q.size() != 0) && (cyc >= q[0].rsp);
            chk("rnd_rspv", rsp_valid, e_rv);
            if (e_rv) begin
                chk("rnd_rsp", {rsp_id, rsp_err, rsp_data}, {q[0].id, 1'b0, f_calc(q[0].op, q[0].opnds)});
                if (rsp_ready) void'(q.pop_front());
            end
            if (e_r0 || e_r1) begin
                t.id    = e_r1;
                t.op    = e_r1 ? req1_op    : req0_op;
                t.opnds = e_r1 ? req1_opnds : req0_opnds;
                t.hs    = cyc;
                t.rsp   = cyc + m_dly + 2;
                q.push_back(t);
                ptr = !e_r1;
            end
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
